// File: rtl/spi_regbank_if.sv
// SPI slave pin bundle: the master drives select/clock/data-in, the regbank drives miso.
interface spi_regbank_if;
    logic spi_cs_n;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_cs_n, spi_clk, spi_mosi, input spi_miso);
    modport slave  (input spi_cs_n, spi_clk, spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_regbank.sv
// SPI slave register bank: NUM_CFG r/w config words and NUM_STATUS read-only status words.
// Define SPI_BURST_EN to let a frame stream consecutive words with auto-incrementing address.
module spi_regbank #(
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8,
    parameter int REG_WIDTH  = 8,
    parameter logic [REG_WIDTH-1:0] CFG_RST = '0
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            ena,
    input  logic [1:0]                      mode,
    spi_regbank_if.slave                    spi,
    input  logic [NUM_STATUS*REG_WIDTH-1:0] status_i,
    output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
    output logic [NUM_CFG-1:0]              cfg_wr_stb
);
    localparam int W        = REG_WIDTH;
    localparam int NUM_REGS = NUM_CFG + NUM_STATUS;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t                       state_q, state_d;
    logic [1:0]                   cs_sync_q, cs_sync_d, sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d;
    logic                         cs_prev_q, cs_prev_d, sclk_prev_q, sclk_prev_d;
    logic [1:0]                   settle_q, settle_d;
    logic [5:0]                   cnt_q, cnt_d;
    logic [W-2:0]                 shift_q, shift_d;
    logic [W-1:0]                 tx_q, tx_d;
    logic                         wr_q, wr_d;
    logic [6:0]                   addr_q, addr_d;
    logic                         miso_q, miso_d;
    logic [NUM_CFG-1:0][W-1:0]    cfg_q, cfg_d;
    logic [NUM_CFG-1:0]           stb_q, stb_d;
    logic [NUM_STATUS-1:0][W-1:0] status_w;

    logic cs_s, sclk_s, mosi_s, cs_fall, cs_rise, sclk_edge, lead, trail, sample, shift_edge;
    logic [W-1:0] word_in;
    logic [7:0]   cmd_in;

    assign status_w    = status_i;
    assign config_regs = cfg_q;
    assign cfg_wr_stb  = stb_q;
    assign spi.spi_miso = miso_q;

    assign cs_s   = cs_sync_q[1];
    assign sclk_s = sclk_sync_q[1];
    assign mosi_s = mosi_sync_q[1];

    // After reset the cs synchroniser starts at 1 while the pin may already be low;
    // falls are only trusted once the chain has flushed, so a frame in flight is skipped.
    assign cs_fall    = (settle_q == 2'd3) && cs_prev_q && !cs_s;
    assign cs_rise    = !cs_prev_q && cs_s;
    assign sclk_edge  = sclk_s ^ sclk_prev_q;
    assign lead       = sclk_edge && (sclk_s != mode[1]);
    assign trail      = sclk_edge && (sclk_s == mode[1]);
    assign sample     = mode[0] ? trail : lead;
    assign shift_edge = mode[0] ? lead : trail;

    assign word_in = {shift_q, mosi_s};
    assign cmd_in  = {shift_q[6:0], mosi_s};

    function automatic logic [W-1:0] rd_word(input logic [6:0] a);
        rd_word = '0;
        for (int k = 0; k < NUM_CFG; k++)
            if (a == 7'(k)) rd_word = cfg_q[k];
        for (int k = 0; k < NUM_STATUS; k++)
            if (a == 7'(NUM_CFG + k)) rd_word = status_w[k];
    endfunction

`ifdef SPI_BURST_EN
    logic [6:0] addr_nxt;
    assign addr_nxt = (addr_q == 7'(NUM_REGS - 1)) ? 7'd0 : addr_q + 7'd1;
`endif

    always_comb begin
        cs_sync_d   = {cs_sync_q[0], spi.spi_cs_n};
        sclk_sync_d = {sclk_sync_q[0], spi.spi_clk};
        mosi_sync_d = {mosi_sync_q[0], spi.spi_mosi};
        cs_prev_d   = cs_s;
        sclk_prev_d = sclk_s;
        settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        miso_d      = miso_q;
        cfg_d       = cfg_q;
        stb_d       = '0;
        if (!ena || cs_rise) begin
            state_d = IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    miso_d = 1'b0;
                    if (cs_fall) begin
                        state_d = CMD;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end
                CMD: begin
                    miso_d = 1'b0;
                    if (sample) begin
                        shift_d = word_in[W-2:0];
                        cnt_d   = cnt_q + 6'd1;
                        if (cnt_q == 6'd7) begin
                            state_d = DATA;
                            cnt_d   = '0;
                            wr_d    = cmd_in[7];
                            addr_d  = cmd_in[6:0];
                            tx_d    = cmd_in[7] ? '0 : rd_word(cmd_in[6:0]);
                        end
                    end
                end
                DATA: begin
                    if (shift_edge) begin
                        miso_d = tx_q[W-1];
                        tx_d   = {tx_q[W-2:0], 1'b0};
                    end
                    if (sample) begin
                        shift_d = word_in[W-2:0];
                        cnt_d   = cnt_q + 6'd1;
                        if (cnt_q == 6'(W - 1)) begin
                            state_d = DONE;
                            cnt_d   = '0;
                            for (int k = 0; k < NUM_CFG; k++)
                                if (wr_q && addr_q == 7'(k)) begin
                                    cfg_d[k] = word_in;
                                    stb_d[k] = 1'b1;
                                end
                        end
                    end
                end
                DONE: begin
`ifdef SPI_BURST_EN
                    state_d = DATA;
                    addr_d  = addr_nxt;
                    tx_d    = wr_q ? '0 : rd_word(addr_nxt);
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            cs_sync_q   <= 2'b11;
            sclk_sync_q <= {2{mode[1]}};
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= mode[1];
            settle_q    <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            miso_q      <= 1'b0;
            cfg_q       <= {NUM_CFG{CFG_RST}};
            stb_q       <= '0;
        end else begin
            state_q     <= state_d;
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_prev_q   <= cs_prev_d;
            sclk_prev_q <= sclk_prev_d;
            settle_q    <= settle_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            cfg_q       <= cfg_d;
            stb_q       <= stb_d;
        end
    end
endmodule

// File: tb/tb_spi_regbank.sv
// Directed + randomized SPI frames against an address-map model of the register bank.
module tb_spi_regbank;
    localparam int H = 80;

    logic        clk = 1'b0;
    logic        rstb;
    logic        ena;
    logic [1:0]  mode;
    logic [63:0] status_i;
    logic [63:0] config_regs;
    logic [7:0]  cfg_wr_stb;

    spi_regbank_if spi();

    spi_regbank #(.NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8), .CFG_RST(8'h00)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .spi(spi),
        .status_i(status_i), .config_regs(config_regs), .cfg_wr_stb(cfg_wr_stb)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] cfg_m [8];
    logic [7:0] status_m [8];

    typedef struct {
        logic [7:0]  stb;
        logic [63:0] regs;
    } stb_ent_t;
    stb_ent_t stb_log [$];

    always @(negedge clk)
        if (cfg_wr_stb != 8'h00) stb_log.push_back('{cfg_wr_stb, config_regs});

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cfg_pack();
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = cfg_m[k];
        return v;
    endfunction

    function automatic logic [7:0] model_rd(input int a);
        if (a < 8) return cfg_m[a];
        if (a < 16) return status_m[a-8];
        return 8'h00;
    endfunction

    task automatic apply_status();
        for (int k = 0; k < 8; k++) status_i[k*8 +: 8] = status_m[k];
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode = m;
        spi.spi_clk = m[1];
        #(4*H);
    endtask

    // ev_kind at bit ev_bit: 1 = clear status word 2, 2 = reset pulse, 3 = ena drop
    task automatic frame(input int nbits, input logic [63:0] tx, input int cut,
                         input int ev_bit, input int ev_kind, output logic [63:0] rx);
        rx = '0;
        spi.spi_clk = mode[1];
        spi.spi_cs_n = 1'b0;
        #(H);
        for (int i = 0; i < nbits; i++) begin
            if (i == cut) break;
            if (i == ev_bit) begin
                if (ev_kind == 1) begin status_m[2] = 8'h00; apply_status(); end
                if (ev_kind == 2) begin rstb = 1'b0; #30; rstb = 1'b1; end
                if (ev_kind == 3) begin ena = 1'b0; #20; ena = 1'b1; end
            end
            if (!mode[0]) begin
                spi.spi_mosi = tx[nbits-1-i];
                #(H);
                spi.spi_clk = ~mode[1];
                rx = {rx[62:0], spi.spi_miso};
                #(H);
                spi.spi_clk = mode[1];
            end else begin
                spi.spi_clk = ~mode[1];
                spi.spi_mosi = tx[nbits-1-i];
                #(H);
                spi.spi_clk = mode[1];
                rx = {rx[62:0], spi.spi_miso};
                #(H);
            end
        end
        #(H);
        spi.spi_cs_n = 1'b1;
        #(4*H);
    endtask

    task automatic check_frame(input string tag, input logic [63:0] rx, input logic [63:0] rx_exp,
                               input int wr_idx, input logic [7:0] wr_val);
        chk({tag, " rx"}, rx, rx_exp);
        chk({tag, " cfg"}, config_regs, cfg_pack());
        chk({tag, " stb_cnt"}, 64'(stb_log.size()), (wr_idx >= 0) ? 64'd1 : 64'd0);
        if (wr_idx >= 0 && stb_log.size() == 1) begin
            chk({tag, " stb_vec"}, 64'(stb_log[0].stb), 64'(1) << wr_idx);
            chk({tag, " stb_data"}, 64'(stb_log[0].regs[wr_idx*8 +: 8]), 64'(wr_val));
        end
        stb_log.delete();
    endtask

    initial begin
        logic [63:0] rx;
        logic [1:0]  m;
        logic        rw;
        logic [6:0]  a;
        logic [7:0]  d;
        rstb = 1'b0; ena = 1'b1; mode = 2'd0; status_i = '0;
        spi.spi_cs_n = 1'b1; spi.spi_clk = 1'b0; spi.spi_mosi = 1'b0;
        for (int k = 0; k < 8; k++) begin cfg_m[k] = 8'h00; status_m[k] = 8'h00; end
        #100;
        chk("reset cfg", config_regs, 64'h0);
        chk("reset stb", 64'(cfg_wr_stb), 64'h0);
        chk("reset miso", 64'(spi.spi_miso), 64'h0);
        rstb = 1'b1;
        #100;

        set_mode(2'd0);
        frame(16, 64'h835A, 16, -1, 0, rx);
        cfg_m[3] = 8'h5A;
        chk("w83 reg3", 64'(config_regs[31:24]), 64'h5A);
        check_frame("w83", rx, 64'h0, 3, 8'h5A);

        status_m[2] = 8'hC3;
        apply_status();
        for (int mi = 0; mi < 4; mi++) begin
            set_mode(2'(mi));
            frame(16, 64'h0A00, 16, -1, 0, rx);
            check_frame($sformatf("rd0A m%0d", mi), rx, 64'h00C3, -1, 8'h00);
        end

        set_mode(2'd0);
        frame(16, 64'h0A00, 16, 10, 1, rx);
        check_frame("snapshot", rx, 64'h00C3, -1, 8'h00);

        frame(16, 64'h85FF, 12, -1, 0, rx);
        check_frame("abort w85", rx, 64'h0, -1, 8'h00);
        frame(16, 64'h8A55, 16, -1, 0, rx);
        check_frame("w8A status", rx, 64'h0, -1, 8'h00);
        frame(16, 64'h7F00, 16, -1, 0, rx);
        check_frame("rd7F", rx, 64'h0, -1, 8'h00);

        set_mode(2'd1);
        frame(16, 64'h8277, 16, 12, 3, rx);
        check_frame("ena drop", rx, 64'h0, -1, 8'h00);
        frame(16, 64'h8277, 16, -1, 0, rx);
        cfg_m[2] = 8'h77;
        check_frame("w82", rx, 64'h0, 2, 8'h77);

        for (int n = 0; n < 30; n++) begin
            m  = 2'($urandom_range(0, 3));
            rw = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(16, 127)) : 7'($urandom_range(0, 15));
            d  = 8'($urandom);
            for (int k = 0; k < 8; k++) status_m[k] = 8'($urandom);
            apply_status();
            set_mode(m);
            frame(16, {48'd0, rw, a, d}, 16, -1, 0, rx);
            if (rw) begin
                if (a < 7'd8) begin
                    cfg_m[a] = d;
                    check_frame($sformatf("rnd%0d wr %0h", n, a), rx, 64'h0, int'(a), d);
                end else
                    check_frame($sformatf("rnd%0d wr %0h", n, a), rx, 64'h0, -1, 8'h00);
            end else
                check_frame($sformatf("rnd%0d rd %0h", n, a), rx, {56'd0, model_rd(int'(a))}, -1, 8'h00);
        end

        set_mode(2'd0);
        frame(16, 64'h813C, 16, 11, 2, rx);
        for (int k = 0; k < 8; k++) cfg_m[k] = 8'h00;
        check_frame("rst midframe", rx, 64'h0, -1, 8'h00);
        frame(16, 64'h813C, 16, -1, 0, rx);
        cfg_m[1] = 8'h3C;
        check_frame("w81 after rst", rx, 64'h0, 1, 8'h3C);

`ifdef SPI_BURST_EN
        frame(24, {40'd0, 8'h87, 8'h11, 8'h22}, 24, -1, 0, rx);
        cfg_m[7] = 8'h11;
        check_frame("burst wr", rx, 64'h0, 7, 8'h11);
        set_mode(2'd1);
        frame(24, {40'd0, 8'h0F, 16'h0000}, 24, -1, 0, rx);
        check_frame("burst rd wrap", rx, {48'd0, status_m[7], cfg_m[0]}, -1, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
